// File: rtl/icache_nway_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache; the master modport drives it.
interface icache_nway_if;
    logic        flush_bus;
    logic        invalidate;
    logic        read_request;
    logic [31:0] addr;
    logic        read_response;
    logic [31:0] read_data;
    logic        memory_read_request;
    logic        memory_read_response;
    logic [31:0] memory_addr;
    logic [31:0] memory_read_data;

    modport master (
        output flush_bus, invalidate, read_request, addr,
        output memory_read_response, memory_read_data,
        input  read_response, read_data,
        input  memory_read_request, memory_addr
    );

    modport slave (
        input  flush_bus, invalidate, read_request, addr,
        input  memory_read_response, memory_read_data,
        output read_response, read_data,
        output memory_read_request, memory_addr
    );
endinterface

// File: rtl/icache_nway.sv
// Set-associative instruction cache, 1 or 2 ways, word-by-word line refill.
// Combinational hits; refill aborts via DRAIN so no memory word is left owed.
module icache_nway #(
    parameter int NUM_SETS   = 16,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    icache_nway_if.slave  bus
);
    localparam int OFF  = $clog2(LINE_WORDS);
    localparam int IDX  = $clog2(NUM_SETS);
    localparam int BW   = 30 - OFF;
    localparam int TAGW = BW - IDX;
    localparam logic [OFF-1:0] LAST = OFF'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, DRAIN} state_t;

    state_t              r_state;
    logic                r_mem_req;
    logic [NUM_SETS-1:0] r_valid [WAYS];
    logic [NUM_SETS-1:0] r_lru;
    logic [TAGW-1:0]     r_tag   [WAYS][NUM_SETS];
    logic [31:0]         r_data  [WAYS][NUM_SETS][LINE_WORDS];
    logic [BW-1:0]       r_base;
    logic [OFF-1:0]      r_cnt;
    logic                r_way;
    logic                r_inv_pend;

    logic [IDX-1:0]  w_idx;
    logic [TAGW-1:0] w_tag;
    logic [OFF-1:0]  w_off;
    logic [IDX-1:0]  w_fill_idx;
    logic [TAGW-1:0] w_fill_tag;
    logic            w_hit;
    logic            w_hit_way;
    logic            w_victim;
    logic            w_lookup;
    logic            w_last;
    logic            w_fill_we;
    logic            w_to_idle;
    logic            w_inv_now;
    logic [1:0]      w_unused_addr;

    assign w_idx         = bus.addr[OFF+IDX+1:OFF+2];
    assign w_tag         = bus.addr[31:OFF+IDX+2];
    assign w_off         = bus.addr[OFF+1:2];
    assign w_unused_addr = bus.addr[1:0];
    assign w_fill_idx    = r_base[IDX-1:0];
    assign w_fill_tag    = r_base[BW-1:IDX];
    assign w_last        = (r_cnt == LAST);

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = w[0];
            end
        end
    end

    // Lowest invalid way wins; the descending loop lets way 0 overwrite.
    always_comb begin
        w_victim = (WAYS == 2) ? r_lru[w_idx] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_idx]) begin
                w_victim = w[0];
            end
        end
    end

    assign w_lookup = (r_state == IDLE) && bus.read_request &&
                      !bus.flush_bus && !bus.invalidate;

    assign w_fill_we = (r_state == REFILL) && bus.memory_read_response &&
                       !bus.flush_bus;

    assign w_to_idle = bus.memory_read_response &&
                       ((r_state == DRAIN) ||
                        ((r_state == REFILL) && (bus.flush_bus || w_last)));

    assign w_inv_now = w_to_idle && (r_inv_pend || bus.invalidate);

    assign bus.read_response       = w_lookup && w_hit;
    assign bus.read_data           = r_data[w_hit_way][w_idx][w_off];
    assign bus.memory_read_request = r_mem_req;
    assign bus.memory_addr         = {r_base, r_cnt, 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_base     <= '0;
            r_cnt      <= '0;
            r_way      <= 1'b0;
            r_inv_pend <= 1'b0;
            r_lru      <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.invalidate) begin
                        for (int w = 0; w < WAYS; w++) begin
                            r_valid[w] <= '0;
                        end
                    end else if (w_lookup && w_hit) begin
                        if (WAYS == 2) r_lru[w_idx] <= ~w_hit_way;
                    end else if (w_lookup) begin
                        r_state  <= REFILL;
                        r_mem_req <= 1'b1;
                        r_base   <= bus.addr[31:OFF+2];
                        r_cnt    <= '0;
                        r_way    <= w_victim;
                        r_valid[w_victim][w_idx] <= 1'b0;
                    end
                end
                REFILL: begin
                    if (bus.invalidate) r_inv_pend <= 1'b1;
                    if (bus.flush_bus) begin
                        r_mem_req <= 1'b0;
                        r_state   <= bus.memory_read_response ? IDLE : DRAIN;
                    end else if (bus.memory_read_response) begin
                        r_cnt <= r_cnt + OFF'(1);
                        if (w_last) begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                            r_valid[r_way][w_fill_idx] <= 1'b1;
                            if (WAYS == 2) r_lru[w_fill_idx] <= ~r_way;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.invalidate) r_inv_pend <= 1'b1;
                    if (bus.memory_read_response) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // Deferred invalidate also kills a line filled this very cycle.
            if (w_inv_now) begin
                r_inv_pend <= 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[w] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_fill_we) begin
            r_data[r_way][w_fill_idx][r_cnt] <= bus.memory_read_data;
            if (w_last) r_tag[r_way][w_fill_idx] <= w_fill_tag;
        end
    end
endmodule

// File: tb/tb_icache_nway.sv
// Scoreboard bench for icache_nway: expected fetch data and memory
// addresses are queued at stimulus time and retired as the DUT produces them.
module tb_icache_nway;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    icache_nway_if bus();

    icache_nway #(
        .NUM_SETS   (16),
        .WAYS       (2),
        .LINE_WORDS (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] q_rd[$];
    logic [31:0] q_ma[$];
    bit          mem_auto = 1'b0;
    bit          mem_force = 1'b0;
    bit          got = 1'b0;
    int          r_wait = 0;
    int          mem_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Fetch scoreboard plus a memory that answers every 2nd request cycle.
    task automatic mon();
        logic [31:0] e;
        if (bus.read_response) begin
            got = 1'b1;
            if (q_rd.size() == 0) begin
                chk("rd_unexp", 32'd1, 32'd0);
            end else begin
                e = q_rd.pop_front();
                chk("rd_data", bus.read_data, e);
            end
        end
        bus.memory_read_response = 1'b0;
        if (!mem_auto) begin
            bus.memory_read_response = mem_force;
            bus.memory_read_data     = 32'hDEAD_BEEF;
        end else if (bus.memory_read_request) begin
            if (q_ma.size() == 0) begin
                chk("maddr_unexp", 32'd1, 32'd0);
            end else begin
                chk("maddr", bus.memory_addr, q_ma[0]);
                r_wait++;
                if (r_wait >= 2) begin
                    r_wait = 0;
                    void'(q_ma.pop_front());
                    bus.memory_read_response = 1'b1;
                    bus.memory_read_data     = mem_word(bus.memory_addr);
                    mem_cnt++;
                end
            end
        end
    endtask

    task automatic cyc();
        #1;
        mon();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_line(input logic [31:0] a);
        for (int i = 0; i < 4; i++) q_ma.push_back((a & ~32'hF) + 32'(4 * i));
    endtask

    task automatic wait_resp(input int start, input int exp_lat,
                             input string tag);
        int n;
        n = start;
        got = 1'b0;
        forever begin
            cyc();
            if (got || n > 200) break;
            n++;
        end
        bus.read_request = 1'b0;
        chk(tag, 32'(n), 32'(exp_lat));
        chk({tag, "_qma"}, 32'(q_ma.size()), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] a, input int nlines,
                         input int exp_lat, input string tag);
        for (int i = 0; i < nlines; i++) push_line(a);
        q_rd.push_back(mem_word(a & ~32'h3));
        mem_auto = 1'b1;
        r_wait = 0;
        bus.read_request = 1'b1;
        bus.addr = a;
        wait_resp(0, exp_lat, tag);
    endtask

    task automatic pulse_inv();
        bus.read_request = 1'b0;
        bus.invalidate = 1'b1;
        cyc();
        bus.invalidate = 1'b0;
    endtask

    initial begin
        int c;
        int n;
        bus.flush_bus = 1'b0;
        bus.invalidate = 1'b0;
        bus.read_request = 1'b0;
        bus.addr = '0;
        bus.memory_read_response = 1'b0;
        bus.memory_read_data = '0;
        @(negedge clk);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_mreq", bus.memory_read_request, 0);
        chk("rst_maddr", bus.memory_addr, 0);
        chk("rst_rresp", bus.read_response, 0);
        cyc();

        // Cold miss then same-line hits.
        fetch(32'h100, 1, 9, "cold_lat");
        fetch(32'h108, 0, 0, "hit108_lat");
        chk("hit_noreq", bus.memory_read_request, 0);
        fetch(32'h104, 0, 0, "hit104_lat");

        // Flush and invalidate mask the lookup in IDLE.
        bus.read_request = 1'b1;
        bus.addr = 32'h100;
        bus.invalidate = 1'b1;
        #1;
        chk("inv_mask", bus.read_response, 0);
        bus.invalidate = 1'b0;
        bus.flush_bus = 1'b1;
        bus.addr = 32'h600;
        cyc();
        bus.flush_bus = 1'b0;
        bus.read_request = 1'b0;
        #1;
        chk("flush_nomiss", bus.memory_read_request, 0);

        pulse_inv();
        fetch(32'h100, 1, 9, "inv_lat");

        // Two-way conflict in set 0.
        pulse_inv();
        fetch(32'h000, 1, 9, "c000_lat");
        fetch(32'h100, 1, 9, "c100_lat");
        fetch(32'h00C, 0, 0, "c000_hit");
        fetch(32'h100, 0, 0, "c100_hit");
        fetch(32'h200, 1, 9, "c200_lat");
        fetch(32'h104, 0, 0, "c100_rehit");
        fetch(32'h000, 1, 9, "c000_evicted");

        // Invalidate mid-refill: line stays invalid so the held fetch refills.
        push_line(32'h200);
        push_line(32'h200);
        q_rd.push_back(mem_word(32'h200));
        mem_auto = 1'b1;
        r_wait = 0;
        got = 1'b0;
        bus.read_request = 1'b1;
        bus.addr = 32'h200;
        cyc();
        cyc();
        cyc();
        bus.invalidate = 1'b1;
        cyc();
        bus.invalidate = 1'b0;
        wait_resp(4, 18, "inv_refill_lat");
        fetch(32'h208, 0, 0, "inv_refill_hit");

        // Flush with the 3rd word outstanding: DRAIN absorbs it.
        q_ma.push_back(32'h340);
        q_ma.push_back(32'h344);
        mem_auto = 1'b1;
        r_wait = 0;
        bus.read_request = 1'b1;
        bus.addr = 32'h348;
        c = mem_cnt;
        n = 0;
        while (mem_cnt < c + 2 && n < 50) begin
            cyc();
            n++;
        end
        chk("fl_words", 32'(mem_cnt - c), 32'd2);
        mem_auto = 1'b0;
        mem_force = 1'b0;
        bus.flush_bus = 1'b1;
        cyc();
        bus.flush_bus = 1'b0;
        bus.read_request = 1'b0;
        #1;
        chk("drain_mreq", bus.memory_read_request, 0);
        mem_force = 1'b1;
        cyc();
        mem_force = 1'b0;
        cyc();
        fetch(32'h348, 1, 9, "fl_refetch_lat");

        // Flush coinciding with the 2nd response: straight back to IDLE.
        q_ma.push_back(32'h380);
        mem_auto = 1'b1;
        r_wait = 0;
        bus.read_request = 1'b1;
        bus.addr = 32'h384;
        c = mem_cnt;
        n = 0;
        while (mem_cnt < c + 1 && n < 50) begin
            cyc();
            n++;
        end
        chk("fr_words", 32'(mem_cnt - c), 32'd1);
        mem_auto = 1'b0;
        mem_force = 1'b1;
        bus.flush_bus = 1'b1;
        cyc();
        mem_force = 1'b0;
        bus.flush_bus = 1'b0;
        #1;
        chk("fr_mreq", bus.memory_read_request, 0);
        push_line(32'h380);
        q_rd.push_back(mem_word(32'h384));
        mem_auto = 1'b1;
        r_wait = 0;
        wait_resp(0, 9, "fr_refetch_lat");

        // Reset in the middle of a refill.
        push_line(32'h400);
        mem_auto = 1'b1;
        r_wait = 0;
        bus.read_request = 1'b1;
        bus.addr = 32'h400;
        cyc();
        cyc();
        cyc();
        rst_n = 1'b0;
        bus.read_request = 1'b0;
        mem_auto = 1'b0;
        cyc();
        #1;
        chk("rst_mid_mreq", bus.memory_read_request, 0);
        rst_n = 1'b1;
        q_ma.delete();
        q_rd.delete();
        cyc();
        fetch(32'h348, 1, 9, "rst_miss_lat");
        fetch(32'h340, 0, 0, "rst_rehit");

        chk("qrd_empty", 32'(q_rd.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/icache_nway.md
# icache_nway

Parametrised set-associative instruction cache with multi-word lines. It sits between the fetch stage and the instruction memory port. It refills a whole line word-by-word on a miss, uses an LRU bit per set when 2-way, aborts cleanly on a pipeline flush, and supports a bulk invalidate for fence.i.

## Interface
- NUM_SETS, 16, number of sets; power of 2, ≥2
- WAYS, 2, associativity; legal values 1 or 2
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥2
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush_bus  in  1  pipeline flush; abandons the current fetch
- invalidate  in  1  single-cycle pulse; clears every valid bit
- read_request  in  1  fetch request; level, held with addr until read_response or flush
- addr  in  32  fetch byte address; bits [1:0] ignored
- read_response  out  1  read_data valid this cycle
- read_data  out  32  requested instruction word
- memory_read_request  out  1  level request to memory, one word per response
- memory_read_response  in  1  one-cycle pulse; memory_read_data valid
- memory_addr  out  32  word address of the outstanding memory read
- memory_read_data  in  32  returned word

## Operation
- Address split:
  - OFF = log2(LINE_WORDS) word-select bits at [OFF+1:2]
  - IDX = log2(NUM_SETS) bits at [OFF+IDX+1:OFF+2]
  - TAG = remaining upper bits
- Hit: read_request and some way has valid=1 with matching tag, flush_bus=0, invalidate=0, FSM in IDLE. read_response and read_data are combinational in the same cycle.
- Each hit or fill sets lru[set] to the other way. With WAYS=1, lru is unused.
- Victim selection: lowest-numbered invalid way; otherwise the way named by lru[set].
- FSM states: IDLE, REFILL, DRAIN.
- IDLE to REFILL: on a miss with flush_bus=0 and invalidate=0.
  - Latch line base and victim way.
  - Clear the victim's valid bit so a partial line is never hit.
  - Word counter = 0.
- REFILL:
  - memory_read_request=1, memory_addr = {line_base, cnt, 2'b00}.
  - On each memory_read_response, write the data into the victim at cnt and increment cnt.
  - After word LINE_WORDS-1: write the tag, set valid, update lru, go to IDLE. The held request hits in the next cycle.
- Flush in REFILL with no response that cycle: go to DRAIN, memory_read_request=0.
- Flush in REFILL coinciding with memory_read_response: discard the word, go to IDLE. The line stays invalid.
- DRAIN: wait for one memory_read_response, discard it, go to IDLE. flush_bus is ignored in DRAIN. A new miss waits until IDLE.
- invalidate in IDLE: clears all valid bits at the edge and masks read_response that cycle.
- invalidate in REFILL/DRAIN: latched as pending and applied on the transition to IDLE, including to a just-filled line.
- flush_bus in IDLE: masks read_response and miss start that cycle.

## Timing
- Reset values:
  - FSM=IDLE; all valid=0, all lru=0, cnt=0, pending invalidate=0.
  - memory_read_request=0, memory_addr=0.
  - read_response=0, since no valid lines exist.
  - read_data is don't-care while read_response=0.
- Reset mid-REFILL/DRAIN: memory_read_request is 0 from the next cycle and no line becomes valid. Memory is expected to be reset by the same rst_n.
- Hit latency: 0 cycles, combinational.
- Miss latency: first memory request asserted the cycle after the miss. read_response comes 1 cycle after the LINE_WORDS-th response.
- memory_addr is stable while memory_read_request=1 and advances the cycle after each response.
- The only outstanding transaction is the one that memory_read_request=1 advertises. The block never deasserts the request while a word is owed, except via DRAIN, which accounts for it.

## Test plan
- Cold miss, defaults, addr=0x100:
  - memory_addr = 0x100, 0x104, 0x108, 0x10C across four responses.
  - read_response 1 cycle after the 4th with word 0.
  - Then addr=0x108 hits in the same cycle with word 2 and no memory request.
- 2-way conflict, set span 0x100: fill 0x000, then 0x100; both re-hit.
  - Access 0x200: evicts the 0x000 line, the LRU victim.
  - 0x100 then hits and 0x000 misses, refilling 4 words.
- Flush after 2 of 4 words, word 3 outstanding:
  - memory_read_request drops next cycle; the 3rd response is discarded; no read_response.
  - A re-request to the same address refetches all 4 words from the line base.
- Flush in the same cycle as the 2nd response: FSM goes straight to IDLE, no DRAIN; the next miss request starts the following cycle.
- invalidate pulse after filling 0x100: the next fetch of 0x100 misses. invalidate asserted during a refill of 0x200 leaves 0x200 invalid after the fill completes.
- rst_n=0 mid-REFILL: memory_read_request=0 the next cycle; after release, a previously filled address misses.
